// File: rtl/cpu_run_ctrl.sv
// ============================================================================
// Module   : cpu_run_ctrl
// Brief    : simpleCPU run controller: reset hold, halt/run/step, PC breakpoint,
//            saturating executed-cycle counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cpu_run_ctrl #(
  parameter int PC_WIDTH   = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int RST_CYCLES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cpu_rst_req,
  input  logic                 i_halt,
  input  logic                 i_step,
  input  logic                 i_run,
  input  logic                 i_bp_en,
  input  logic [PC_WIDTH-1:0]  i_bp_addr,
  input  logic [PC_WIDTH-1:0]  i_pc,
  output logic                 o_cpu_en,
  output logic                 o_cpu_rst,
  output logic [1:0]           o_state,
  output logic                 o_bp_hit,
  output logic [CNT_WIDTH-1:0] o_cycles
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0]      RC_LOAD = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CYC_MAX = '1;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_HALT  = 2'd1,
    S_RUN   = 2'd2,
    S_STEP  = 2'd3
  } state_t;

  state_t               state_q;
  logic [RC_W-1:0]      rcnt_q;
  logic                 skip_q;
  logic                 bp_hit_q;
  logic                 cpu_rst_q;
  logic [CNT_WIDTH-1:0] cycles_q;
  logic [CNT_WIDTH-1:0] cycles_d;
  logic                 cpu_en_d;
  logic                 bp_match;

  always_comb begin
    bp_match = i_bp_en && (i_pc == i_bp_addr);
  end

  // The enable drops in the very cycle the PC sits on the breakpoint, so the
  // instruction there never executes; skip lets a resume execute it once.
  always_comb begin
    cpu_en_d = 1'b0;
    case (state_q)
      S_RUN:   cpu_en_d = !(bp_match && !skip_q);
      S_STEP:  cpu_en_d = 1'b1;
      default: cpu_en_d = 1'b0;
    endcase
  end

  always_comb begin
    cycles_d = cycles_q;
    if (cpu_en_d && (cycles_q != CYC_MAX)) begin
      cycles_d = cycles_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_cpu_rst_req) begin
      state_q   <= S_RESET;
      rcnt_q    <= RC_LOAD;
      cpu_rst_q <= 1'b1;
      bp_hit_q  <= 1'b0;
      skip_q    <= 1'b0;
      cycles_q  <= '0;
    end else begin
      cycles_q <= cycles_d;
      case (state_q)
        S_RESET: begin
          cycles_q <= '0;
          bp_hit_q <= 1'b0;
          if (rcnt_q == '0) begin
            state_q   <= S_HALT;
            cpu_rst_q <= 1'b0;
          end else begin
            rcnt_q <= rcnt_q - 1'b1;
          end
        end
        // i_halt outranks step/run, so a halt pulse here swallows them.
        S_HALT: begin
          if (!i_halt) begin
            if (i_step) begin
              state_q  <= S_STEP;
              bp_hit_q <= 1'b0;
            end else if (i_run) begin
              state_q  <= S_RUN;
              skip_q   <= 1'b1;
              bp_hit_q <= 1'b0;
            end
          end
        end
        S_RUN: begin
          skip_q <= 1'b0;
          if (bp_match && !skip_q) begin
            state_q  <= S_HALT;
            bp_hit_q <= 1'b1;
          end else if (i_halt) begin
            state_q <= S_HALT;
          end
        end
        S_STEP: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_RESET;
        end
      endcase
    end
  end

  assign o_cpu_en  = cpu_en_d;
  assign o_cpu_rst = cpu_rst_q;
  assign o_state   = state_q;
  assign o_bp_hit  = bp_hit_q;
  assign o_cycles  = cycles_q;

endmodule

`default_nettype wire

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run controller for the simpleCPU core, sitting in `top_wrapper` between the board buttons/switches and the CPU. It generates the CPU's clock-enable and core reset, so the CPU can be held in reset, halted, free-run or single-stepped. It halts on a PC breakpoint and counts executed cycles for the logging bench. All command inputs are single-cycle pulses already debounced and synchronised upstream.

## Interface
- `PC_WIDTH`, 8, width of CPU program counter and breakpoint address
- `CNT_WIDTH`, 16, width of executed-cycle counter
- `RST_CYCLES`, 4, cycles `o_cpu_rst` is held after any reset (≥1)

Ports:
- `i_clk` in 1: the single clock; all logic on its rising edge
- `i_rst` in 1: synchronous, active-high reset
- `i_cpu_rst_req` in 1: pulse, soft reset of the CPU
- `i_halt` in 1: pulse, stop execution
- `i_step` in 1: pulse, execute exactly one CPU cycle
- `i_run` in 1: pulse, free-run
- `i_bp_en` in 1: breakpoint enable (level)
- `i_bp_addr` in PC_WIDTH: breakpoint address (level)
- `i_pc` in PC_WIDTH: current CPU `r_pc`
- `o_cpu_en` out 1: CPU clock-enable
- `o_cpu_rst` out 1: CPU synchronous reset, active-high
- `o_state` out 2: 0=RESET, 1=HALT, 2=RUN, 3=STEP
- `o_bp_hit` out 1: sticky, last halt was caused by breakpoint
- `o_cycles` out CNT_WIDTH: cycles with `o_cpu_en`=1, saturating

## Operation
Definition: `bp_match = i_bp_en && (i_pc == i_bp_addr)`.

FSM states:
- **RESET**
  - Actions: `o_cpu_rst`=1, `o_cpu_en`=0, `o_cycles` cleared, `o_bp_hit` cleared.
  - Down-counter loaded with RST_CYCLES-1.
  - At 0, go to HALT. Command pulses are ignored in this state except `i_cpu_rst_req`, which reloads the counter.
- **HALT**
  - `o_cpu_en`=0.
  - `i_step` → STEP.
  - `i_run` → RUN and set the skip flag.
  - Leaving HALT by `i_step` or `i_run` clears `o_bp_hit`.
- **RUN**
  - `o_cpu_en = !(bp_match && !skip)`.
  - `bp_match && !skip` → HALT and set `o_bp_hit`; the instruction at the breakpoint is not executed.
  - `i_halt` → HALT.
  - The skip flag is set on entry to RUN and cleared after the first RUN cycle, so resuming from a breakpoint executes that instruction once.
- **STEP**
  - `o_cpu_en`=1 for exactly one cycle; the breakpoint is ignored.
  - Then go to HALT unconditionally.

Command priority:
- Same-cycle priority is `i_cpu_rst_req` > `i_halt` > `i_step` > `i_run`.
- `i_cpu_rst_req` in any state → RESET.
- `i_halt` in HALT is a no-op.
- `i_run` in RUN is a no-op.
- `i_step` in RUN is ignored.
- In STEP, `i_halt`, `i_run` and `i_step` are ignored; only `i_cpu_rst_req` is honoured.

`o_cycles`:
- Increments on every cycle `o_cpu_en`=1.
- Saturates at 2^CNT_WIDTH−1; it does not wrap.

Combinational outputs: `o_cpu_en` is a function of state, skip and `bp_match`; all other outputs are registered.

## Timing
- Reset values (i_rst=1): state=RESET, counter=RST_CYCLES-1, `o_cpu_rst`=1, `o_cpu_en`=0, `o_bp_hit`=0, `o_cycles`=0, `o_state`=0, skip=0.
- After `i_rst` falls, `o_cpu_rst` stays 1 for exactly RST_CYCLES cycles, then `o_state`=1.
- Command latency: a pulse sampled at edge N changes `o_state` after edge N.
  - `o_cpu_en` goes to 1 in the cycle after an `i_step`/`i_run` pulse.
  - `o_cpu_en` goes to 0 in the cycle after an `i_halt` pulse.
- Breakpoint: `o_cpu_en` drops in the same cycle `i_pc` equals `i_bp_addr`, so zero instructions execute at that address. `o_state`=1 from the next cycle.
- Changing `i_bp_addr` or `i_bp_en` mid-RUN takes effect combinationally in that cycle.
- `i_rst` or `i_cpu_rst_req` mid-RUN/STEP: `o_cpu_en`=0 from the next cycle and `o_cycles` cleared; no partial step survives.

## Test plan
- **Reset release.** Hold `i_rst` 10 cycles, release. Required: `o_cpu_rst`=1 for 4 more cycles, `o_state`=1, `o_cpu_en`=0, `o_cycles`=0.
- **Single step.** From HALT, three `i_step` pulses spaced 5 cycles apart. Required: three isolated 1-cycle `o_cpu_en` pulses, `o_cycles`=3, `o_state` returns to 1 each time.
- **Breakpoint.** Breakpoint at 0x10 (`i_bp_en`=1, `i_bp_addr`=0x10), `i_run`, bench PC model increments on enable from 0x00. Required: halt with `i_pc`=0x10, `o_cycles`=16, `o_bp_hit`=1. A second `i_run` executes 0x10; PC reaches 0x11 and `o_bp_hit`=0.
- **Same-cycle priority.** `i_halt` and `i_run` in the same cycle while in HALT. Required: state remains HALT. `i_cpu_rst_req` and `i_step` in the same cycle. Required: RESET for 4 cycles.
- **Saturation.** CNT_WIDTH=4, free-run 40 cycles. Required: `o_cycles` sticks at 15.
- **Mid-run reset.** `i_cpu_rst_req` at RUN cycle 7. Required: `o_cpu_en`=0 and `o_cpu_rst`=1 next cycle, `o_cycles`=0, `o_state`=1 four cycles later.
